// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/PC stage: FSM state encoding and default widths.
// PC_BITS_DEF must match the instruction memory address width.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam int PC_BITS_DEF      = 12;
    localparam int OFF_BITS_DEF     = 6;
    localparam int LUT_SEL_BITS_DEF = 3;
    localparam int CNT_BITS_DEF     = 16;

endpackage

// File: rtl/fetch_pc_ctrl_jump_target_lut.sv
// Jump-target table: register array with a synchronous write and a combinational read.
// A read in the same cycle as a write to that index returns the old entry.
module jump_target_lut #(
    parameter int SEL_BITS  = 3,
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [SEL_BITS-1:0]  waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [SEL_BITS-1:0]  raddr,
    output logic [DATA_BITS-1:0] rdata
);

    localparam int ENTRIES = 2 ** SEL_BITS;

    logic [DATA_BITS-1:0] mem_q [ENTRIES];
    logic [DATA_BITS-1:0] mem_d [ENTRIES];

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Program counter and fetch sequencing (IDLE/RUN/HALTED) ahead of the instruction memory.
// pc, running and done are all flops, so instruction fetch sees a stable address all cycle.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_BITS      = PC_BITS_DEF,
    parameter int LUT_SEL_BITS = LUT_SEL_BITS_DEF,
    parameter int OFF_BITS     = OFF_BITS_DEF,
    parameter int CNT_BITS     = CNT_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stall,
    input  logic                    halt_req,
    input  logic                    br_rel_en,
    input  logic [OFF_BITS-1:0]     br_off,
    input  logic                    jmp_en,
    input  logic [LUT_SEL_BITS-1:0] jmp_sel,
    input  logic                    lut_we,
    input  logic [LUT_SEL_BITS-1:0] lut_waddr,
    input  logic [PC_BITS-1:0]      lut_wdata,
    output logic [PC_BITS-1:0]      pc,
    output logic                    running,
    output logic                    done,
    output logic [CNT_BITS-1:0]     cycle_cnt,
    output logic [1:0]              state_dbg
);

    localparam logic [PC_BITS-1:0]  PC_ONE  = {{(PC_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    fetch_state_e        state_q, state_d;
    logic [PC_BITS-1:0]  pc_q, pc_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                running_q, running_d;
    logic                done_q, done_d;

    logic [PC_BITS-1:0]  lut_rdata;
    logic [PC_BITS-1:0]  br_off_ext;

    jump_target_lut #(
        .SEL_BITS  (LUT_SEL_BITS),
        .DATA_BITS (PC_BITS)
    ) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (jmp_sel),
        .rdata (lut_rdata)
    );

    assign br_off_ext = {{(PC_BITS-OFF_BITS){br_off[OFF_BITS-1]}}, br_off};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (!stall) begin
                    // Jump beats relative branch; PC arithmetic wraps naturally.
                    if (jmp_en) begin
                        pc_d = lut_rdata;
                    end else if (br_rel_en) begin
                        pc_d = pc_q + br_off_ext;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign pc        = pc_q;
    assign running   = running_q;
    assign done      = done_q;
    assign cycle_cnt = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: each step drives inputs, queues the expected
// post-edge outputs, then pops and compares them one time unit after the edge.
module tb_fetch_pc_ctrl;
    import fetch_pkg::*;

    localparam int W = 32;  // {state[1:0], running, done, cnt[15:0], pc[11:0]}

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stall, halt_req, br_rel_en, jmp_en, lut_we;
    logic [5:0]  br_off;
    logic [2:0]  jmp_sel, lut_waddr;
    logic [11:0] lut_wdata;
    logic [11:0] pc;
    logic        running, done;
    logic [15:0] cycle_cnt;
    logic [1:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .halt_req  (halt_req),
        .br_rel_en (br_rel_en),
        .br_off    (br_off),
        .jmp_en    (jmp_en),
        .jmp_sel   (jmp_sel),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .pc        (pc),
        .running   (running),
        .done      (done),
        .cycle_cnt (cycle_cnt),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input int step, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed 0x%0h expected 0x%0h", tag, step, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic st, input logic h, input logic b,
                         input logic [5:0] o, input logic j, input logic [2:0] js);
        start     = s;
        stall     = st;
        halt_req  = h;
        br_rel_en = b;
        br_off    = o;
        jmp_en    = j;
        jmp_sel   = js;
    endtask

    task automatic lut_w(input logic we, input logic [2:0] addr, input logic [11:0] data);
        lut_we    = we;
        lut_waddr = addr;
        lut_wdata = data;
    endtask

    // Queue the expected outputs, clock once, then pop and compare.
    task automatic step_exp(input int step, input logic [1:0] st, input logic run, input logic dn,
                            input logic [15:0] cnt, input logic [11:0] p);
        logic [W-1:0] e;
        exp_q.push_back({st, run, dn, cnt, p});
        @(posedge clk);
        #1;
        n_assert++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL queue step %0d: observed empty expected entry", step);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("state", step, {30'd0, state_dbg}, {30'd0, e[31:30]});
            check("running", step, {31'd0, running}, {31'd0, e[29]});
            check("done", step, {31'd0, done}, {31'd0, e[28]});
            check("cycle_cnt", step, {16'd0, cycle_cnt}, {16'd0, e[27:12]});
            check("pc", step, {20'd0, pc}, {20'd0, e[11:0]});
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 6'd0, 0, 3'd0);
        lut_w(0, 3'd0, 12'h000);
        step_exp(0, IDLE, 0, 0, 16'd0, 12'h000);

        // IDLE ignores everything except start
        reset = 1'b0;
        drive(0, 1, 1, 1, 6'd5, 1, 3'd3);
        step_exp(1, IDLE, 0, 0, 16'd0, 12'h000);

        drive(1, 0, 0, 0, 6'd0, 0, 3'd0);
        step_exp(2, RUN, 1, 0, 16'd0, 12'h000);
        drive(0, 0, 0, 0, 6'd0, 0, 3'd0);
        for (int i = 1; i <= 5; i++) begin
            step_exp(2 + i, RUN, 1, 0, 16'(i), 12'(i));
        end

        lut_w(1, 3'd3, 12'h0A0);
        step_exp(8, RUN, 1, 0, 16'd6, 12'h006);
        lut_w(1, 3'd1, 12'h010);
        step_exp(9, RUN, 1, 0, 16'd7, 12'h007);
        lut_w(0, 3'd0, 12'h000);
        drive(0, 0, 0, 0, 6'd0, 1, 3'd3);
        step_exp(10, RUN, 1, 0, 16'd8, 12'h0A0);
        // start is ignored while running
        drive(1, 0, 0, 1, 6'b111110, 0, 3'd0);
        step_exp(11, RUN, 1, 0, 16'd9, 12'h09E);
        // jump beats branch
        drive(0, 0, 0, 1, 6'd5, 1, 3'd1);
        step_exp(12, RUN, 1, 0, 16'd10, 12'h010);

        drive(0, 1, 0, 1, 6'd5, 0, 3'd0);
        lut_w(1, 3'd2, 12'hFFF);
        step_exp(13, RUN, 1, 0, 16'd10, 12'h010);
        lut_w(1, 3'd4, 12'h001);
        step_exp(14, RUN, 1, 0, 16'd10, 12'h010);
        lut_w(1, 3'd6, 12'h020);
        step_exp(15, RUN, 1, 0, 16'd10, 12'h010);
        lut_w(0, 3'd0, 12'h000);
        drive(0, 0, 0, 1, 6'd5, 0, 3'd0);
        step_exp(16, RUN, 1, 0, 16'd11, 12'h015);

        drive(0, 0, 0, 0, 6'd0, 1, 3'd2);
        step_exp(17, RUN, 1, 0, 16'd12, 12'hFFF);
        drive(0, 0, 0, 0, 6'd0, 0, 3'd0);
        step_exp(18, RUN, 1, 0, 16'd13, 12'h000);
        drive(0, 0, 0, 0, 6'd0, 1, 3'd4);
        step_exp(19, RUN, 1, 0, 16'd14, 12'h001);
        drive(0, 0, 0, 1, 6'b111100, 0, 3'd0);
        step_exp(20, RUN, 1, 0, 16'd15, 12'hFFD);

        // same-cycle write and jump read the old entry
        drive(0, 0, 0, 0, 6'd0, 1, 3'd5);
        lut_w(1, 3'd5, 12'h123);
        step_exp(21, RUN, 1, 0, 16'd16, 12'h000);
        lut_w(0, 3'd0, 12'h000);
        step_exp(22, RUN, 1, 0, 16'd17, 12'h123);
        drive(0, 0, 0, 0, 6'd0, 1, 3'd6);
        step_exp(23, RUN, 1, 0, 16'd18, 12'h020);

        drive(0, 1, 1, 0, 6'd0, 1, 3'd3);
        step_exp(24, HALTED, 0, 1, 16'd18, 12'h020);
        drive(0, 0, 0, 1, 6'd5, 1, 3'd3);
        step_exp(25, HALTED, 0, 1, 16'd18, 12'h020);

        drive(1, 0, 0, 0, 6'd0, 0, 3'd0);
        lut_w(1, 3'd7, 12'h040);
        step_exp(26, RUN, 1, 0, 16'd0, 12'h000);
        lut_w(0, 3'd0, 12'h000);
        drive(0, 0, 0, 0, 6'd0, 1, 3'd7);
        step_exp(27, RUN, 1, 0, 16'd1, 12'h040);

        // reset mid-run overrides a same-cycle LUT write
        reset = 1'b1;
        lut_w(1, 3'd0, 12'h555);
        step_exp(28, IDLE, 0, 0, 16'd0, 12'h000);
        reset = 1'b0;
        lut_w(0, 3'd0, 12'h000);
        drive(0, 0, 0, 0, 6'd0, 0, 3'd0);
        step_exp(29, IDLE, 0, 0, 16'd0, 12'h000);
        drive(1, 0, 0, 0, 6'd0, 0, 3'd0);
        step_exp(30, RUN, 1, 0, 16'd0, 12'h000);
        drive(0, 0, 0, 0, 6'd0, 1, 3'd0);
        step_exp(31, RUN, 1, 0, 16'd1, 12'h000);
        drive(0, 0, 0, 0, 6'd0, 1, 3'd7);
        step_exp(32, RUN, 1, 0, 16'd2, 12'h000);
        drive(0, 0, 0, 0, 6'd0, 0, 3'd0);
        step_exp(33, RUN, 1, 0, 16'd3, 12'h001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
